example: RTL and testbench
==========================

EXAMPLE -- requirements
Module: example

Interface
REQ-001 Parameter TT, default 8'h31, 8-bit truth table; bit index {a,b,c} gives the function value, with a as the MSB.
REQ-002 Parameter CNT_W, default 8, width of the high-cycle counter; legal range 2..32.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 a  input  1  function input, MSB of the truth-table index.
REQ-006 b  input  1  function input, middle bit of the index.
REQ-007 c  input  1  function input, LSB of the index.
REQ-008 y  output  1  registered function value.
REQ-009 y_rise  output  1  one-cycle pulse when y goes from 0 to 1.
REQ-010 hi_cnt  output  CNT_W  saturating count of cycles in which y=1.

Function
REQ-011 At each rising clk edge with reset_n=1, the next value of y SHALL be TT[{a,b,c}], using a,b,c as sampled at that edge.
- Latency: exactly 1 clock.
- No combinational path from a,b,c to any output.
REQ-012 With the default TT, y SHALL equal (~a&~b&~c) | (a&~b&~c) | (a&~b&c), i.e. (~b&~c) | (a&~b).
- {a,b,c} 000->1, 001->0, 010->0, 011->0, 100->1, 101->1, 110->0, 111->0.
REQ-013 y_rise SHALL be registered and SHALL be 1 for exactly the one cycle in which y=1 after a cycle in which y=0.
REQ-014 The first cycle after reset release SHALL count y's previous value as 0.
- So y=1 in that first cycle gives y_rise=1.
REQ-015 hi_cnt SHALL increment by 1 at every rising edge where y is currently 1 and reset_n=1.
REQ-016 hi_cnt SHALL saturate at 2^CNT_W-1 and hold there; it SHALL NOT wrap to 0.
REQ-017 hi_cnt SHALL hold its value at edges where y=0.
REQ-018 hi_cnt SHALL reflect y's value before the edge.
- Count after edge N = count of y=1 cycles up to and including cycle N-1.
REQ-019 Inputs SHALL be treated as synchronous to clk; no synchronizers SHALL be included.
REQ-020 X/Z on a, b or c SHALL NOT be resolved by the block; behaviour is undefined until valid inputs are applied.
REQ-021 Any TT value SHALL be supported, including all-0 and all-1; no other logic depends on the TT value.

Reset
REQ-022 When reset_n=0 at a rising edge, y, y_rise and hi_cnt SHALL all become 0 at that edge.
REQ-023 Reset SHALL be synchronous.
- Asserting reset_n mid-operation has no effect until the next rising edge.
- Reset SHALL override all other updates, including counter saturation.
REQ-024 In the first edge after reset_n returns to 1, y SHALL load TT[{a,b,c}]; hi_cnt SHALL stay 0 because y was 0 during reset.
REQ-025 Output values before the first reset edge are unspecified.

Verification
REQ-026 Exhaustive sweep:
- Reset, then apply {a,b,c}=000..111 ascending, one vector per cycle.
- Required: y one cycle later = 1,0,0,0,1,1,0,0.
REQ-027 Rise pulse and counter during the sweep:
- y_rise=1 only in the cycles where y first shows the 000 result and the 100 result.
- hi_cnt after the sweep plus one idle cycle with {a,b,c}=111 = 3.
REQ-028 Saturation, with CNT_W=2:
- Hold {a,b,c}=000 for 6 cycles after reset.
- Required: hi_cnt 0,1,2,3,3,3; y_rise high only in the first cycle where y=1.
REQ-029 Mid-run reset:
- With y=1 and hi_cnt=5, drive reset_n=0 for one edge.
- Required: y=0, y_rise=0, hi_cnt=0 after that edge.
- Outputs SHALL be unchanged between the reset_n fall and that edge.
REQ-030 Alternate truth table:
- Set TT=8'h96 (3-input XOR) and run the exhaustive sweep.
- Required: y = 0,1,1,0,1,0,0,1, each one cycle after its vector.
REQ-031 Glitch-free latency:
- Toggle a between edges while b and c are held.
- Required: y changes only at rising edges, reflecting the values sampled at those edges.

Source files
------------

// File: rtl/example.sv
// Registered 3-input truth-table function with a rising-edge pulse and a
// saturating count of cycles in which the output is high.
module example #(
  parameter logic [7:0]  TT    = 8'h31,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  output logic             y_rise,
  output logic [CNT_W-1:0] hi_cnt
);

  logic [2:0]       idx;
  logic             y_d, y_q;
  logic             rise_d, rise_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    idx    = {a, b, c};
    y_d    = TT[idx];
    // y_q is 0 while in reset, so the first cycle after release sees a 0 history
    rise_d = y_d & ~y_q;
    cnt_d  = cnt_q;
    if (y_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_q    <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      y_q    <= y_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y      = y_q;
  assign y_rise = rise_q;
  assign hi_cnt = cnt_q;

endmodule

// File: tb/tb_example.sv
// Directed bench: default table, CNT_W=2 saturation variant and XOR table,
// all driven from the same stimulus.
module tb_example;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a, b, c;
  logic       d_y, d_rise;
  logic [7:0] d_cnt;
  logic       s_y, s_rise;
  logic [1:0] s_cnt;
  logic       x_y, x_rise;
  logic [7:0] x_cnt;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  example u_def (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .c(c),
    .y(d_y), .y_rise(d_rise), .hi_cnt(d_cnt)
  );

  example #(.CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .c(c),
    .y(s_y), .y_rise(s_rise), .hi_cnt(s_cnt)
  );

  example #(.TT(8'h96)) u_xor (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .c(c),
    .y(x_y), .y_rise(x_rise), .hi_cnt(x_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    {a, b, c} = 3'b000;
    tick();
    tick();
    checks++;
    if ({d_y, d_rise, d_cnt} !== 10'd0) $display("FAIL reset_def: got %b required 0", {d_y, d_rise, d_cnt});
    else passes++;
    checks++;
    if ({s_y, s_rise, s_cnt} !== 4'd0) $display("FAIL reset_sat: got %b required 0", {s_y, s_rise, s_cnt});
    else passes++;
    checks++;
    if ({x_y, x_rise, x_cnt} !== 10'd0) $display("FAIL reset_xor: got %b required 0", {x_y, x_rise, x_cnt});
    else passes++;
  endtask

  task automatic test_sweep();
    logic [7:0] exp_y   = 8'b0011_0001;  // bit i = y after vector i (default TT)
    logic [7:0] exp_r   = 8'b0001_0001;
    logic [7:0] exp_x   = 8'b1001_0110;  // XOR table
    int         exp_c[8] = '{0, 1, 1, 1, 1, 2, 3, 3};
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      tick();
      checks++;
      if (d_y !== exp_y[i]) $display("FAIL sweep_y[%0d]: got %b required %b", i, d_y, exp_y[i]);
      else passes++;
      checks++;
      if (d_rise !== exp_r[i]) $display("FAIL sweep_rise[%0d]: got %b required %b", i, d_rise, exp_r[i]);
      else passes++;
      checks++;
      if (d_cnt !== 8'(exp_c[i])) $display("FAIL sweep_cnt[%0d]: got %0d required %0d", i, d_cnt, exp_c[i]);
      else passes++;
      checks++;
      if (x_y !== exp_x[i]) $display("FAIL xor_y[%0d]: got %b required %b", i, x_y, exp_x[i]);
      else passes++;
    end
    {a, b, c} = 3'b111;
    tick();
    checks++;
    if (d_cnt !== 8'd3) $display("FAIL sweep_final_cnt: got %0d required 3", d_cnt);
    else passes++;
    checks++;
    if (d_y !== 1'b0) $display("FAIL sweep_idle_y: got %b required 0", d_y);
    else passes++;
  endtask

  task automatic test_saturation();
    int exp_s[6] = '{0, 1, 2, 3, 3, 3};
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    {a, b, c} = 3'b000;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (s_cnt !== 2'(exp_s[k])) $display("FAIL sat_cnt[%0d]: got %0d required %0d", k, s_cnt, exp_s[k]);
      else passes++;
      checks++;
      if (s_rise !== (k == 0)) $display("FAIL sat_rise[%0d]: got %b required %b", k, s_rise, k == 0);
      else passes++;
      checks++;
      if (d_cnt !== 8'(k)) $display("FAIL def_cnt[%0d]: got %0d required %0d", k, d_cnt, k);
      else passes++;
    end
  endtask

  task automatic test_midrun_reset();
    // Continues from test_saturation: default y=1, hi_cnt=5; sat hi_cnt=3
    reset_n = 1'b0;
    #3;
    checks++;
    if ({d_y, d_cnt} !== {1'b1, 8'd5}) $display("FAIL midrst_pre: got y=%b cnt=%0d required y=1 cnt=5", d_y, d_cnt);
    else passes++;
    tick();
    checks++;
    if ({d_y, d_rise, d_cnt} !== 10'd0) $display("FAIL midrst_def: got %b required 0", {d_y, d_rise, d_cnt});
    else passes++;
    checks++;
    if ({s_y, s_rise, s_cnt} !== 4'd0) $display("FAIL midrst_sat: got %b required 0", {s_y, s_rise, s_cnt});
    else passes++;
  endtask

  task automatic test_glitch();
    reset_n = 1'b1;
    {a, b, c} = 3'b001;
    tick();
    checks++;
    if (d_y !== 1'b0) $display("FAIL glitch_y0: got %b required 0", d_y);
    else passes++;
    a = 1'b1;
    #2;
    checks++;
    if (d_y !== 1'b0) $display("FAIL glitch_mid0: got %b required 0", d_y);
    else passes++;
    a = 1'b0;
    tick();
    checks++;
    if (d_y !== 1'b0) $display("FAIL glitch_y1: got %b required 0", d_y);
    else passes++;
    a = 1'b1;
    tick();
    checks++;
    if (d_y !== 1'b1) $display("FAIL glitch_y2: got %b required 1", d_y);
    else passes++;
    a = 1'b0;
    #2;
    checks++;
    if (d_y !== 1'b1) $display("FAIL glitch_mid1: got %b required 1", d_y);
    else passes++;
    tick();
    checks++;
    if (d_y !== 1'b0) $display("FAIL glitch_y3: got %b required 0", d_y);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_saturation();
    test_midrun_reset();
    test_glitch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
